// File: rtl/spawn_ctrl_pkg.sv
// Shared types and helpers for the car-spawn trigger: FSM state, switch popcount
// and the density-dependent spawn threshold.
package spawn_pkg;

  typedef enum logic {ARMED = 1'b0, COOL = 1'b1} state_t;

  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c = c + int'(v[i]);
    return c;
  endfunction

  // (2^rand_w - 1) - level*STEP. level never exceeds n_sw, so the result stays
  // at or above half scale and cannot wrap.
  function automatic logic [32:0] calc_thresh(input int rand_w, input int n_sw, input int level);
    logic [32:0] full;
    logic [32:0] step;
    full = 33'(1) << rand_w;
    step = full / 33'(2 * n_sw);
    return (full - 33'(1)) - (33'(level) * step);
  endfunction

endpackage

// File: rtl/spawn_ctrl_lane_arbiter.sv
// One-hot lane grant for a spawn, combinational from lane_busy and gated by the fire strobe.
// SPAWN_CTRL_ROUNDROBIN_EN selects round-robin with a pointer; otherwise lowest free lane wins.
module lane_arbiter #(
  parameter int N_LANES = 4
) (
`ifdef SPAWN_CTRL_ROUNDROBIN_EN
  input  logic               i_clk,
  input  logic               i_reset,
`endif
  input  logic [N_LANES-1:0] i_lane_busy,
  input  logic               i_fire,
  output logic [N_LANES-1:0] o_grant
);

  logic [N_LANES-1:0] w_pick;

`ifdef SPAWN_CTRL_ROUNDROBIN_EN
  localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] w_idx;

  // Walk the search order backwards so the last hit is the first free lane from r_ptr.
  always_comb begin
    w_pick    = '0;
    w_ptr_nxt = r_ptr;
    w_idx     = '0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % N_LANES);
      if (!i_lane_busy[w_idx]) begin
        w_pick        = '0;
        w_pick[w_idx] = 1'b1;
        w_ptr_nxt     = PTR_W'((int'(w_idx) + 1) % N_LANES);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_fire && (|w_pick)) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  always_comb begin
    w_pick = '0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (!i_lane_busy[k]) begin
        w_pick    = '0;
        w_pick[k] = 1'b1;
      end
    end
  end
`endif

  assign o_grant = i_fire ? w_pick : '0;

endmodule

// File: rtl/spawn_ctrl.sv
// Spawn trigger: threshold compare, ARMED/COOL cooldown FSM and saturating spawn count; 1-cycle registered pulse.
// enable low freezes all state and zeroes trigger; SPAWN_CTRL_ROUNDROBIN_EN picks round-robin lane select.
module spawn_ctrl
  import spawn_pkg::*;
#(
  parameter int N_SW    = 6,
  parameter int RAND_W  = 10,
  parameter int N_LANES = 4,
  parameter int MIN_GAP = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_SW-1:0]    SW,
  input  logic [RAND_W-1:0]  rand_in,
  input  logic               OF,
  input  logic [N_LANES-1:0] lane_busy,
  output logic [N_LANES-1:0] trigger,
  output logic [CNT_W-1:0]   spawn_count
);

  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic [N_LANES-1:0] r_trigger;
  logic [CNT_W-1:0]   r_count;
  logic [N_LANES-1:0] w_grant;
  int                 w_level;
  logic [32:0]        w_thresh;
  logic [32:0]        w_rand_ext;
  logic               w_req;
  logic               w_any_free;
  logic               w_fire;

  assign w_level    = popcount(32'(SW));
  assign w_thresh   = calc_thresh(RAND_W, N_SW, w_level);
  assign w_rand_ext = 33'(rand_in);
  assign w_req      = OF || ((w_level != 0) && (w_rand_ext > w_thresh));
  assign w_any_free = ~&lane_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap_cnt;
    w_fire      = 1'b0;
    case (r_state)
      ARMED: begin
        // A request with every lane busy is simply dropped, never queued.
        if (enable && w_req && w_any_free) begin
          w_fire = 1'b1;
          if (MIN_GAP > 0) begin
            w_state_nxt = COOL;
            w_gap_nxt   = GAP_W'(MIN_GAP - 1);
          end
        end
      end
      COOL: begin
        if (r_gap_cnt == '0) w_state_nxt = ARMED;
        else                 w_gap_nxt   = r_gap_cnt - GAP_W'(1);
      end
      default: w_state_nxt = ARMED;
    endcase
  end

  lane_arbiter #(
    .N_LANES(N_LANES)
  ) u_lane_arbiter (
`ifdef SPAWN_CTRL_ROUNDROBIN_EN
    .i_clk      (clk),
    .i_reset    (reset),
`endif
    .i_lane_busy(lane_busy),
    .i_fire     (w_fire),
    .o_grant    (w_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ARMED;
      r_gap_cnt <= '0;
      r_trigger <= '0;
      r_count   <= '0;
    end else if (enable) begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_trigger <= w_grant;
      if (w_fire && (r_count != CNT_MAX)) r_count <= r_count + CNT_W'(1);
    end else begin
      r_trigger <= '0;
    end
  end

  assign trigger     = r_trigger;
  assign spawn_count = r_count;

endmodule

// File: tb/tb_spawn_ctrl.sv
// Bench for spawn_ctrl: directed scenarios with literal expectations, then random traffic
// compared every cycle against a cycle-level behavioural model.
module tb_spawn_ctrl;

  localparam int N_SW    = 6;
  localparam int RAND_W  = 10;
  localparam int NL      = 4;
  localparam int MIN_GAP = 2;
  localparam int CNT_W   = 16;
`ifdef SPAWN_CTRL_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              t_reset = 1'b1;
  logic              t_en = 1'b1;
  logic [N_SW-1:0]   t_sw = '0;
  logic [RAND_W-1:0] t_rand = '0;
  logic              t_of = 1'b0;
  logic [NL-1:0]     t_busy = '0;
  logic [NL-1:0]     trigger;
  logic [CNT_W-1:0]  spawn_count;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // model state: pulses forbidden for m_block more enabled cycles
  logic [NL-1:0] m_trig = '0;
  int            m_cnt = 0;
  int            m_block = 0;
  int            m_ptr = 0;

  always #5 clk = ~clk;

  spawn_ctrl #(
    .N_SW(N_SW), .RAND_W(RAND_W), .N_LANES(NL), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(t_reset), .enable(t_en), .SW(t_sw), .rand_in(t_rand),
    .OF(t_of), .lane_busy(t_busy), .trigger(trigger), .spawn_count(spawn_count)
  );

  function automatic int model_thresh(input int lvl);
    return (2 ** RAND_W - 1) - lvl * ((2 ** RAND_W) / (2 * N_SW));
  endfunction

  function automatic logic [NL-1:0] lane_exp(input int rr_lane);
    logic [NL-1:0] one;
    one = 1;
    return RR ? (one << rr_lane) : one;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int lvl;
    int found;
    int l;
    if (t_reset) begin
      m_trig = '0; m_cnt = 0; m_block = 0; m_ptr = 0;
    end else if (!t_en) begin
      m_trig = '0;
    end else if (m_block > 0) begin
      m_block = m_block - 1;
      m_trig  = '0;
    end else begin
      m_trig = '0;
      lvl = $countones(t_sw);
      if (t_of || (lvl != 0 && int'(t_rand) > model_thresh(lvl))) begin
        found = -1;
        for (int k = 0; k < NL; k++) begin
          l = RR ? (m_ptr + k) % NL : k;
          if (found < 0 && !t_busy[l]) found = l;
        end
        if (found >= 0) begin
          m_trig  = NL'(1 << found);
          m_cnt   = (m_cnt == 2 ** CNT_W - 1) ? m_cnt : m_cnt + 1;
          m_block = MIN_GAP;
          m_ptr   = (found + 1) % NL;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_trigger", 32'(trigger), 32'(m_trig));
      check("model_count", 32'(spawn_count), 32'(m_cnt));
      check("onehot", 32'($countones(trigger) <= 1), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    t_reset = 1'b1; t_en = 1'b1; t_of = 1'b0; t_busy = '0;
    step(); step();
    t_reset = 1'b0;
  endtask

  initial begin
    check("thresh_lvl1", 32'(model_thresh(1)), 32'd938);
    check("thresh_lvl6", 32'(model_thresh(6)), 32'd513);

    // reset held with a request present
    t_sw = 6'b111111; t_rand = 10'd1000;
    @(posedge clk); chk_on = 1'b1; @(negedge clk);
    check("rst_trig", 32'(trigger), 32'd0);
    check("rst_cnt", 32'(spawn_count), 32'd0);
    step();
    check("rst_trig2", 32'(trigger), 32'd0);
    t_reset = 1'b0;
    step();
    check("first_pulse", 32'(trigger), 32'(lane_exp(0)));
    check("first_cnt", 32'(spawn_count), 32'd1);

    // density 0 never spawns unless OF
    do_reset();
    t_sw = '0; t_rand = 10'd1023;
    for (int i = 0; i < 10; i++) begin
      step();
      check("dens0_nopulse", 32'(trigger), 32'd0);
    end
    t_of = 1'b1;
    step();
    check("of_pulse", 32'(trigger), 32'(lane_exp(0)));
    t_of = 1'b0;

    // strict threshold edge at level 1
    do_reset();
    t_sw = 6'b000001; t_rand = 10'd938;
    for (int i = 0; i < 3; i++) begin
      step();
      check("thr_eq_nopulse", 32'(trigger), 32'd0);
    end
    t_rand = 10'd939;
    step();
    check("thr_above_pulse", 32'(trigger), 32'(lane_exp(0)));
    t_rand = 10'd0;
    step(); step(); step();
    check("thr_cnt", 32'(spawn_count), 32'd1);

    // cooldown spacing and lane rotation
    do_reset();
    t_sw = 6'b111111; t_rand = 10'd1000;
    for (int i = 0; i < 13; i++) begin
      step();
      check("rotate", 32'(trigger), (i % 3 == 0) ? 32'(lane_exp((i / 3) % NL)) : 32'd0);
    end
    check("rotate_cnt", 32'(spawn_count), 32'd5);

    // busy lanes
    do_reset();
    t_sw = 6'b111111; t_rand = 10'd1000; t_busy = 4'b0011;
    step();
    check("busy_lane2", 32'(trigger), 32'b0100);
    t_sw = '0; t_rand = '0; t_busy = '0;
    step(); step();
    t_busy = 4'b1111; t_of = 1'b1;
    step();
    check("allbusy_nopulse", 32'(trigger), 32'd0);
    check("allbusy_cnt", 32'(spawn_count), 32'd1);
    t_busy = '0;
    step();
    check("after_busy_lane", 32'(trigger), 32'(lane_exp(3)));
    t_of = 1'b0;

    // pause freezes cooldown
    do_reset();
    t_sw = 6'b111111; t_rand = 10'd1000;
    step();
    check("pause_first", 32'(trigger), 32'(lane_exp(0)));
    t_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("paused_nopulse", 32'(trigger), 32'd0);
    end
    t_en = 1'b1;
    step(); check("resume_e1", 32'(trigger), 32'd0);
    step(); check("resume_e2", 32'(trigger), 32'd0);
    step(); check("resume_e3", 32'(trigger), 32'(lane_exp(1)));
    check("resume_cnt", 32'(spawn_count), 32'd2);

    // reset during COOL
    do_reset();
    step();
    check("cool_pre", 32'(trigger), 32'(lane_exp(0)));
    t_reset = 1'b1;
    step();
    check("cool_rst_trig", 32'(trigger), 32'd0);
    check("cool_rst_cnt", 32'(spawn_count), 32'd0);
    t_reset = 1'b0;
    step();
    check("cool_rst_armed", 32'(trigger), 32'(lane_exp(0)));
    check("cool_rst_cnt1", 32'(spawn_count), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      t_reset = ($urandom_range(0, 199) == 0);
      t_en    = ($urandom_range(0, 99) < 85);
      t_sw    = N_SW'($urandom);
      t_rand  = RAND_W'($urandom);
      t_of    = ($urandom_range(0, 15) == 0);
      t_busy  = NL'($urandom) & NL'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spawn_ctrl.md
# spawn_ctrl

Parametrised multi-lane car-spawn trigger for the traffic game. Each enabled cycle it compares a random word from the LFSR/adder path against a threshold set by the number of active density switches. When a spawn is due, it issues a one-cycle trigger on one free lane, chosen round-robin. A configurable cooldown between spawns limits density, and a saturating counter records the total number of spawns. It sits between the random-number path and the per-lane car shift registers.

## Interface
- N_SW, 6, number of density switches
- RAND_W, 10, width of random input
- N_LANES, 4, number of spawn lanes
- MIN_GAP, 2, idle cycles forced after each spawn (0 allowed)
- CNT_W, 16, spawn counter width
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high reset
- enable  in  1  advance strobe; when low, all state holds
- SW  in  N_SW  density switches
- rand_in  in  RAND_W  random word
- OF  in  1  adder overflow; forces a spawn request
- lane_busy  in  N_LANES  lane cannot accept a car this cycle
- trigger  out  N_LANES  one-hot or zero spawn pulse, registered
- spawn_count  out  CNT_W  saturating total of issued spawns

## Operation
- Density level: level = popcount(SW), range 0..N_SW.
- Threshold:
  - STEP = 2^RAND_W / (2*N_SW), integer division.
  - thresh = (2^RAND_W - 1) - level*STEP, computed at RAND_W+1 bits with no wrap.
- Spawn request: req = OF || (level != 0 && rand_in > thresh).
  - Comparison is unsigned and strict.
  - OF overrides level 0.
- The FSM has two states: ARMED and COOL.
- ARMED, with enable=1:
  - req=1 and at least one free lane: fire on the selected lane.
    - If MIN_GAP>0, go to COOL with gap_cnt=MIN_GAP-1.
    - If MIN_GAP=0, stay in ARMED.
  - req=1 and all lanes busy: drop the request. No pulse, no pending request, counter unchanged, stay in ARMED.
  - req=0: stay in ARMED.
- COOL, with enable=1:
  - req is ignored.
  - If gap_cnt==0, go to ARMED; otherwise decrement gap_cnt.
- Lane select (round-robin):
  - Search lanes from ptr, wrapping modulo N_LANES, and take the first with lane_busy=0.
  - On a fire, ptr becomes (selected+1) mod N_LANES.
  - ptr holds when nothing fires.
- spawn_count: increments by 1 on each fire and saturates at 2^CNT_W-1.
- enable=0:
  - trigger is driven to 0 on the next edge.
  - State, gap_cnt, ptr and spawn_count hold.

## Timing
- Latency: a request evaluated on the inputs sampled at edge t produces a trigger pulse visible after edge t, for exactly one cycle. spawn_count updates on the same edge.
- Minimum spacing: pulse in cycle k means no pulse in cycles k+1..k+MIN_GAP, provided enable stays high. The earliest next pulse is cycle k+MIN_GAP+1.
- Reset values: trigger=0, spawn_count=0, state=ARMED, gap_cnt=0, ptr=0.
- Reset has priority over enable.
- Reset during COOL returns the block to ARMED on the next edge, with no pulse.
- Simultaneous reset and request: reset wins, no pulse.
- At most one bit of trigger is ever high.

## Configuration
- SPAWN_CTRL_ROUNDROBIN_EN:
  - Defined: round-robin lane select with the ptr register, as described above.
  - Undefined: fixed priority, lowest-index free lane. No ptr register is instantiated.

## Structure
- Package spawn_pkg:
  - state enum (ARMED, COOL)
  - popcount function
  - STEP/threshold helper function
- Sub-module lane_arbiter:
  - Inputs: lane_busy, fire strobe.
  - Output: one-hot grant.
  - Owns ptr under SPAWN_CTRL_ROUNDROBIN_EN.
- spawn_ctrl owns the FSM, gap counter, threshold compare and spawn counter.

## Test plan
Default parameters give STEP=85, thresh(1)=938 and thresh(6)=513. MIN_GAP=2.
- Reset: reset=1 for 2 cycles with SW=6'b111111, rand_in=1000 -> trigger=0 and spawn_count=0 throughout. First pulse is on lane 0 in the cycle after reset is released.
- Density 0: SW=0, OF=0, rand_in=1023 for 10 cycles -> no pulse. Then OF=1 -> lane-0 pulse one cycle later.
- Threshold edge: SW=6'b000001, rand_in=938 -> no pulse. rand_in=939 -> one pulse.
- Cooldown and rotation: SW=6'b111111, rand_in=1000, lane_busy=0 held -> pulses on lanes 0,1,2,3,0, one every 3 cycles. spawn_count reads 5 afterwards. Fixed-priority build gives lane 0 every time.
- Busy lanes: ptr=0, lane_busy=4'b0011 -> pulse on lane 2, ptr becomes 3. lane_busy=4'b1111 with OF=1 -> no pulse, state ARMED, spawn_count unchanged.
- Pause and mid-reset:
  - Drop enable for 5 cycles right after a pulse -> COOL is frozen. Once enable returns high, the next pulse comes no sooner than 3 enabled cycles after the original pulse.
  - Assert reset during COOL -> ARMED with spawn_count=0 on the next edge.
